// File: rtl/input_link_router_dispatch.sv
// Dispatch stage after the input link router ingress: decodes each TLP's destination and
// serialises its header DWs, then payload DWs, into one subunit input buffer or the transmit link.
module input_link_router_dispatch #(
    parameter int DATA_WIDTH       = 32,
    parameter int SUBUNIT_QUANTITY = 4,
    parameter int LINK_NUMBER      = 0,
    parameter int DEST_LSB         = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [127:0]          header_in,
    input  logic [DATA_WIDTH-1:0] payload_in,
    input  logic                  in_ready,
    output logic                  next_ready,
    input  logic [3:0]            hardware_subunit_input_buffer_full,
    input  logic                  transmit_link_output_buffer_full,
    output logic [DATA_WIDTH-1:0] sub_data,
    output logic [3:0]            sub_wr,
    output logic                  sub_last,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_wr,
    output logic                  tx_last,
    output logic [7:0]            link_id,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t       state;
    logic [127:0] hdr_q;
    logic [1:0]   idx_q;
    logic [10:0]  cnt_q;
    logic         is_4dw_q;
    logic         has_data_q;
    logic         to_tx_q;
    logic [1:0]   sub_sel_q;
    logic         ready_q;

    logic [2:0]            cap_fmt;
    logic [7:0]            cap_dest;
    logic                  cap_to_tx;
    logic [10:0]           cap_len;
    logic                  dest_full;
    logic [1:0]            last_idx;
    logic                  beat_valid;
    logic                  beat_last;
    logic [DATA_WIDTH-1:0] beat_data;

    // Routing DW is DW3 for 4DW headers, DW2 otherwise.
    assign cap_fmt   = header_in[31:29];
    assign cap_dest  = cap_fmt[0] ? header_in[96+DEST_LSB +: 8] : header_in[64+DEST_LSB +: 8];
    assign cap_to_tx = {24'd0, cap_dest} >= 32'(SUBUNIT_QUANTITY);
    assign cap_len   = (header_in[9:0] == 10'd0) ? 11'd1024 : {1'b0, header_in[9:0]};

    assign dest_full  = to_tx_q ? transmit_link_output_buffer_full
                                : hardware_subunit_input_buffer_full[sub_sel_q];
    assign last_idx   = is_4dw_q ? 2'd3 : 2'd2;
    assign next_ready = ready_q && (state == IDLE || (state == PAY && !dest_full));
    assign busy       = (state != IDLE);
    assign link_id    = 8'(LINK_NUMBER);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        beat_data  = hdr_q[32*idx_q +: 32];
        case (state)
            HDR: begin
                beat_valid = !dest_full;
                beat_last  = !has_data_q && (idx_q == last_idx);
            end
            PAY: begin
                beat_valid = in_ready && !dest_full;
                beat_last  = (cnt_q == 11'd1);
                beat_data  = payload_in;
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            // NOTE: the header register is cleared too, so a stale header can never be strobed.
            hdr_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            is_4dw_q   <= 1'b0;
            has_data_q <= 1'b0;
            to_tx_q    <= 1'b0;
            sub_sel_q  <= '0;
            ready_q    <= 1'b0;
            sub_data   <= '0;
            sub_wr     <= '0;
            sub_last   <= 1'b0;
            tx_data    <= '0;
            tx_wr      <= 1'b0;
            tx_last    <= 1'b0;
        end else begin
            ready_q  <= 1'b1;
            sub_wr   <= '0;
            tx_wr    <= 1'b0;
            sub_last <= 1'b0;
            tx_last  <= 1'b0;
            if (beat_valid) begin
                if (to_tx_q) begin
                    tx_wr   <= 1'b1;
                    tx_data <= beat_data;
                    tx_last <= beat_last;
                end else begin
                    sub_wr   <= 4'b0001 << sub_sel_q;
                    sub_data <= beat_data;
                    sub_last <= beat_last;
                end
            end
            case (state)
                IDLE: if (in_ready && next_ready) begin
                    hdr_q      <= header_in;
                    is_4dw_q   <= cap_fmt[0];
                    has_data_q <= cap_fmt[1];
                    cnt_q      <= cap_len;
                    to_tx_q    <= cap_to_tx;
                    sub_sel_q  <= cap_dest[1:0];
                    idx_q      <= '0;
                    state      <= HDR;
                end
                HDR: if (beat_valid) begin
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == last_idx) state <= has_data_q ? PAY : IDLE;
                end
                PAY: if (beat_valid) begin
                    cnt_q <= cnt_q - 11'd1;
                    if (cnt_q == 11'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_link_router_dispatch.sv
// Bench for input_link_router_dispatch: directed table, hand-written corner sequences and
// randomised TLPs with random buffer-full flags, all scored against a beat-list reference model.
module tb_input_link_router_dispatch;
    typedef struct packed {
        logic        is_tx;
        logic [1:0]  sub;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [127:0] hdr;
        int           gap;
        logic         exp_tx;
        logic [1:0]   exp_sub;
        int           exp_beats;
    } vec_t;

    localparam logic [127:0] H1 = 128'h00000000_33333333_22222222_0F000000;
    localparam logic [127:0] H2 = 128'h00000001_22222222_11111111_6F000002;
    localparam logic [127:0] H5 = 128'h00000002_000000FF_AAAA0001_60000004;
    localparam logic [127:0] H6 = 128'h00000000_00000003_11110000_00000001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] header_in = '0;
    logic [31:0]  payload_in = '0;
    logic         in_ready = 1'b0;
    logic [3:0]   sub_full = '0;
    logic         tx_full = 1'b0;
    logic [3:0]   dir_sub = '0;
    logic         dir_tx = 1'b0;
    logic         rand_flags = 1'b0;

    logic        next_ready, sub_last, tx_wr, tx_last, busy;
    logic [31:0] sub_data, tx_data;
    logic [3:0]  sub_wr;
    logic [7:0]  link_id;
    logic        d2_next_ready, d2_sub_last, d2_tx_wr, d2_tx_last, d2_busy;
    logic [31:0] d2_sub_data, d2_tx_data;
    logic [3:0]  d2_sub_wr;
    logic [7:0]  d2_link_id;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t obs[$];
    beat_t exp_q[$];
    logic [31:0] pay_buf [0:1023];
    logic [31:0] t1_dw [3] = '{32'h0F000000, 32'h22222222, 32'h33333333};
    vec_t  tbl [7];
    int    d2_tx = 0, d2_sub = 0, d2_last = 0;

    input_link_router_dispatch #(.SUBUNIT_QUANTITY(4), .LINK_NUMBER(0)) dut (
        .clk(clk), .rst_n(rst_n), .header_in(header_in), .payload_in(payload_in),
        .in_ready(in_ready), .next_ready(next_ready),
        .hardware_subunit_input_buffer_full(sub_full),
        .transmit_link_output_buffer_full(tx_full),
        .sub_data(sub_data), .sub_wr(sub_wr), .sub_last(sub_last),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_last(tx_last),
        .link_id(link_id), .busy(busy)
    );

    input_link_router_dispatch #(.SUBUNIT_QUANTITY(2), .LINK_NUMBER(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .header_in(header_in), .payload_in(payload_in),
        .in_ready(in_ready), .next_ready(d2_next_ready),
        .hardware_subunit_input_buffer_full(sub_full),
        .transmit_link_output_buffer_full(tx_full),
        .sub_data(d2_sub_data), .sub_wr(d2_sub_wr), .sub_last(d2_sub_last),
        .tx_data(d2_tx_data), .tx_wr(d2_tx_wr), .tx_last(d2_tx_last),
        .link_id(d2_link_id), .busy(d2_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Full flags only ever change just after a rising edge.
    always @(posedge clk) begin
        #1;
        if (rand_flags) begin
            for (int b = 0; b < 4; b++) sub_full[b] = ($urandom_range(0, 3) == 0);
            tx_full = ($urandom_range(0, 3) == 0);
        end else begin
            sub_full = dir_sub;
            tx_full  = dir_tx;
        end
    end

    // Collect every strobe of the main instance as a beat record.
    logic [3:0] prev_sub_full = '0;
    logic       prev_tx_full = 1'b0;
    always @(negedge clk) begin
        beat_t b;
        logic  pf;
        if (tx_wr || (sub_wr != 4'd0)) begin
            check("single_destination", 64'($onehot({tx_wr, sub_wr})), 64'd1);
            b = '0;
            if (tx_wr) begin
                b.is_tx = 1'b1;
                b.data  = tx_data;
                b.last  = tx_last;
                pf      = prev_tx_full;
            end else begin
                for (int k = 0; k < 4; k++) if (sub_wr[k]) b.sub = 2'(k);
                b.data = sub_data;
                b.last = sub_last;
                pf     = prev_sub_full[b.sub];
            end
            check("no_beat_while_full", 64'(pf), 64'd0);
            obs.push_back(b);
        end
        prev_sub_full = sub_full;
        prev_tx_full  = tx_full;
    end

    always @(negedge clk) begin
        if (d2_tx_wr) d2_tx++;
        if (d2_tx_wr && d2_tx_last) d2_last++;
        if (d2_sub_wr != 4'd0) d2_sub++;
    end

    // Reference: the whole TLP as the ordered list of beats the destination must receive.
    function automatic void build_expected(input logic [127:0] h, input int sq);
        logic [2:0]  fmt;
        logic [31:0] rdw;
        int          ndw, len, dest;
        beat_t       b;
        fmt  = h[31:29];
        ndw  = fmt[0] ? 4 : 3;
        len  = (h[9:0] == 10'd0) ? 1024 : int'(h[9:0]);
        rdw  = fmt[0] ? h[127:96] : h[95:64];
        dest = int'(rdw[7:0]);
        b = '0;
        b.is_tx = (dest >= sq);
        b.sub   = b.is_tx ? 2'd0 : 2'(dest);
        for (int i = 0; i < ndw; i++) begin
            b.data = h[32*i +: 32];
            b.last = !fmt[1] && (i == ndw - 1);
            exp_q.push_back(b);
        end
        if (fmt[1]) begin
            for (int i = 0; i < len; i++) begin
                b.data = pay_buf[i];
                b.last = (i == len - 1);
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic wait_accept(input string what);
        bit ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (next_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: next_ready stayed 0 for 3000 cycles, required 1", what);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_tlp(input logic [127:0] h, input int gap, input int sq);
        int len;
        build_expected(h, sq);
        header_in = h;
        in_ready  = 1'b1;
        wait_accept("header");
        in_ready  = 1'b0;
        if (h[30]) begin
            len = (h[9:0] == 10'd0) ? 1024 : int'(h[9:0]);
            for (int i = 0; i < len; i++) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
                payload_in = pay_buf[i];
                in_ready   = 1'b1;
                wait_accept("payload");
                in_ready   = 1'b0;
            end
        end
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: busy stayed 1 for 3000 cycles, required 0");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, 64'(obs.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), 64'(obs[i]), 64'(exp_q[i]));
        obs.delete();
        exp_q.delete();
    endtask

    function automatic void fill_pattern();
        for (int i = 0; i < 1024; i++) pay_buf[i] = 32'h40404040 + 32'(i) * 32'h10101010;
    endfunction

    initial begin
        int d2_tx0, d2_sub0, d2_last0;
        fill_pattern();
        tbl[0] = '{H1, 0, 1'b1, 2'd0, 3};
        tbl[1] = '{H2, 0, 1'b0, 2'd1, 6};
        tbl[2] = '{128'h12345678_00000002_9ABCDEF0_40000003, 2, 1'b0, 2'd2, 6};
        tbl[3] = '{128'h000000FF_00000001_CAFEF00D_20000000, 0, 1'b1, 2'd0, 4};
        tbl[4] = '{128'hFFFFFFFF_00000000_01020304_40000000, 0, 1'b0, 2'd0, 1027};
        tbl[5] = '{128'h00000000_00000103_00000000_00000000, 0, 1'b0, 2'd3, 3};
        tbl[6] = '{128'h00000000_00000004_00000000_1F000000, 1, 1'b1, 2'd0, 3};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_sub_wr", 64'(sub_wr), 64'd0);
        check("rst_tx_wr", 64'(tx_wr), 64'd0);
        check("rst_lasts", 64'({sub_last, tx_last}), 64'd0);
        check("rst_data", 64'({sub_data, tx_data}), 64'd0);
        check("rst_next_ready", 64'(next_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_link_id", 64'(link_id), 64'd0);
        check("rst_link_id2", 64'(d2_link_id), 64'd5);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(next_ready), 64'd1);
        @(posedge clk);
        #1;

        // 3DW no-data TLP to the transmit link, cycle by cycle
        build_expected(H1, 4);
        header_in = H1;
        in_ready  = 1'b1;
        @(negedge clk);
        check("t1_ready_idle", 64'(next_ready), 64'd1);
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        @(negedge clk);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_no_strobe_yet", 64'(tx_wr), 64'd0);
        check("t1_ready_hdr", 64'(next_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("t1_tx_wr%0d", k), 64'(tx_wr), 64'd1);
            check($sformatf("t1_tx_data%0d", k), 64'(tx_data), 64'(t1_dw[k]));
            check($sformatf("t1_tx_last%0d", k), 64'(tx_last), 64'(k == 2));
            check($sformatf("t1_next_ready%0d", k), 64'(next_ready), 64'(k == 2));
        end
        @(negedge clk);
        check("t1_strobe_done", 64'(tx_wr), 64'd0);
        drain();
        compare("t1");

        // Directed table
        for (int v = 0; v < 7; v++) begin
            send_tlp(tbl[v].hdr, tbl[v].gap, 4);
            drain();
            check($sformatf("tbl%0d_beats", v), 64'(obs.size()), 64'(tbl[v].exp_beats));
            if (obs.size() > 0) begin
                check($sformatf("tbl%0d_is_tx", v), 64'(obs[0].is_tx), 64'(tbl[v].exp_tx));
                check($sformatf("tbl%0d_sub", v), 64'(obs[0].sub), 64'(tbl[v].exp_sub));
            end
            compare($sformatf("tbl%0d", v));
        end

        // Subunit 1 full for 3 cycles while header DW1 is due
        fork
            send_tlp(H2, 0, 4);
            begin
                for (int n = 0; n < 50; n++) begin
                    @(negedge clk);
                    if (busy) break;
                end
                dir_sub = 4'b0010;
                repeat (3) @(negedge clk);
                dir_sub = 4'b0000;
            end
        join
        drain();
        compare("bp");

        // Reset in the middle of the payload
        build_expected(H5, 4);
        header_in = H5;
        in_ready  = 1'b1;
        wait_accept("rst_header");
        payload_in = pay_buf[0];
        wait_accept("rst_pay0");
        payload_in = pay_buf[1];
        wait_accept("rst_pay1");
        in_ready = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_sub_wr", 64'(sub_wr), 64'd0);
        check("midrst_tx_wr", 64'(tx_wr), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_next_ready", 64'(next_ready), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_hold_ready", 64'(next_ready), 64'd0);
            check("midrst_hold_sub_wr", 64'(sub_wr), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_idle", 64'(next_ready), 64'd1);
        check("midrst_partial_count", 64'(obs.size()), 64'd6);
        for (int i = 0; i < 6 && i < obs.size(); i++)
            check($sformatf("midrst_partial%0d", i), 64'(obs[i]), 64'(exp_q[i]));
        obs.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        send_tlp(H1, 0, 4);
        drain();
        compare("after_rst");

        // Same 3DW TLP to dest 3: subunit 3 with four subunits, transmit link with two
        d2_tx0 = d2_tx;
        d2_sub0 = d2_sub;
        d2_last0 = d2_last;
        send_tlp(H6, 0, 4);
        drain();
        compare("sq4_dest3");
        check("sq2_tx_beats", 64'(d2_tx - d2_tx0), 64'd3);
        check("sq2_tx_last", 64'(d2_last - d2_last0), 64'd1);
        check("sq2_sub_beats", 64'(d2_sub - d2_sub0), 64'd0);

        // Randomised TLPs with random backpressure
        rand_flags = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [31:0]  r0, r1, r2, r3, rt;
            logic [1:0]   fmt;
            logic [127:0] h;
            r0 = $urandom;
            r1 = $urandom;
            r2 = $urandom;
            r3 = $urandom;
            fmt = 2'($urandom_range(0, 3));
            rt = {r3[31:8], 8'($urandom_range(0, 7))};
            h[31:0]   = {1'b0, fmt, r0[27:10], 10'($urandom_range(1, 6))};
            h[63:32]  = r1;
            h[95:64]  = fmt[0] ? r2 : rt;
            h[127:96] = fmt[0] ? rt : r3;
            for (int i = 0; i < 6; i++) pay_buf[i] = $urandom;
            send_tlp(h, int'($urandom_range(0, 2)), 4);
            drain();
            compare($sformatf("rand%0d", t));
        end
        rand_flags = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
